// File: rtl/mtx4x2_pkg.sv
`default_nettype none
// mtx4x2_pkg -- shared HTRANS/arbiter encodings for the 4x2 bus matrix (rev 1.0)
package mtx4x2_pkg;

  localparam int c_idx_w = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_GRANT  = 2'b01,
    ARB_LOCKED = 2'b10
  } arb_state_e;

  function automatic logic [c_idx_w-1:0] wrap_inc(input logic [c_idx_w-1:0] base,
                                                  input int off, input int n);
    return c_idx_w'((int'(base) + off) % n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtx4x2_rr_pick.sv
`default_nettype none
// mtx4x2_rr_pick -- combinational winner search (rev 1.0)
// MTX4X2_ARB_FIXED_PRI_EN selects lowest-index-wins instead of round-robin.
import mtx4x2_pkg::*;

module mtx4x2_rr_pick #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [c_idx_w-1:0]   i_last,
  output logic [c_idx_w-1:0]   o_winner,
  output logic                 o_found
);

`ifdef MTX4X2_ARB_FIXED_PRI_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;

  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (i_req[c_idx_w'(k)]) begin
        o_winner = c_idx_w'(k);
        o_found  = 1'b1;
      end
    end
  end
`else
  // Scan farthest-first so the nearest port after i_last is written last and wins.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (i_req[wrap_inc(i_last, k, NUM_PORTS)]) begin
        o_winner = wrap_inc(i_last, k, NUM_PORTS);
        o_found  = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mtx4x2_out_arb.sv
`default_nettype none
// mtx4x2_out_arb -- MI1 output-stage arbiter with burst/lock hold (rev 1.0)
// MTX4X2_ARB_FIXED_PRI_EN: fixed priority, no last-grant pointer.
import mtx4x2_pkg::*;

module mtx4x2_out_arb #(
  parameter int NUM_PORTS = 4,
  parameter int RST_LAST  = NUM_PORTS - 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_PORTS-1:0]   sel_in,
  input  logic [2*NUM_PORTS-1:0] trans_in,
  input  logic [NUM_PORTS-1:0]   lock_in,
  input  logic                   HREADYM,
  output logic [c_idx_w-1:0]     addr_in_port,
  output logic                   no_port,
  output logic [NUM_PORTS-1:0]   active_out,
  output logic [c_idx_w-1:0]     data_in_port,
  output logic                   data_valid
);

  arb_state_e           r_state, w_state_nxt;
  logic [c_idx_w-1:0]   r_addr_port, w_addr_nxt;
  logic                 r_no_port, w_no_port_nxt;
  logic [c_idx_w-1:0]   r_data_port;
  logic                 r_data_valid;
  logic [NUM_PORTS-1:0] w_req;
  logic [c_idx_w-1:0]   w_last, w_winner;
  logic                 w_found, w_rearb, w_owner_lock;
  htrans_e              w_owner_trans;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_req[gi]      = sel_in[gi] & trans_in[2*gi+1];
    assign active_out[gi] = ~r_no_port & (r_addr_port == c_idx_w'(gi));
  end

  assign w_owner_trans = htrans_e'(trans_in[{r_addr_port, 1'b0} +: 2]);
  assign w_owner_lock  = lock_in[r_addr_port];

  mtx4x2_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .i_req    (w_req),
    .i_last   (w_last),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr_port;
    w_no_port_nxt = r_no_port;
    w_rearb       = 1'b0;
    unique case (r_state)
      ARB_IDLE: w_rearb = 1'b1;
      ARB_GRANT, ARB_LOCKED: begin
        if (w_owner_lock) begin
          w_state_nxt = ARB_LOCKED;
        end else if (w_owner_trans == HTRANS_SEQ || w_owner_trans == HTRANS_BUSY) begin
          w_state_nxt = ARB_GRANT;
        end else begin
          w_rearb = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
    // Losing all requesters keeps the old index; only no_port flags the idle bus.
    if (w_rearb) begin
      if (w_found) begin
        w_state_nxt   = ARB_GRANT;
        w_addr_nxt    = w_winner;
        w_no_port_nxt = 1'b0;
      end else begin
        w_state_nxt   = ARB_IDLE;
        w_no_port_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ARB_IDLE;
      r_addr_port  <= '0;
      r_no_port    <= 1'b1;
      r_data_port  <= '0;
      r_data_valid <= 1'b0;
    end else if (HREADYM) begin
      r_state      <= w_state_nxt;
      r_addr_port  <= w_addr_nxt;
      r_no_port    <= w_no_port_nxt;
      r_data_port  <= r_addr_port;
      r_data_valid <= ~r_no_port & w_owner_trans[1];
    end
  end

`ifdef MTX4X2_ARB_FIXED_PRI_EN
  assign w_last = '0;
`else
  logic [c_idx_w-1:0] r_last;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_last <= c_idx_w'(RST_LAST);
    else if (HREADYM && w_rearb && w_found)
      r_last <= w_winner;
  end
  assign w_last = r_last;
`endif

  assign addr_in_port = r_addr_port;
  assign no_port      = r_no_port;
  assign data_in_port = r_data_port;
  assign data_valid   = r_data_valid;

  a_active_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETn)
    $onehot0(active_out));
  a_addr_range: assert property (@(posedge HCLK) disable iff (!HRESETn)
    int'(addr_in_port) < NUM_PORTS);
  a_idle_inactive: assert property (@(posedge HCLK) disable iff (!HRESETn)
    no_port |-> (active_out == '0));

endmodule
`default_nettype wire

// File: tb/tb_mtx4x2_out_arb.sv
`default_nettype none
// tb_mtx4x2_out_arb -- directed scenarios plus random traffic against an ownership model (rev 1.0)
module tb_mtx4x2_out_arb;

  localparam int N = 4;

  logic         HCLK, HRESETn, HREADYM;
  logic [N-1:0] sel_in, lock_in;
  logic [2*N-1:0] trans_in;
  logic [1:0]   addr_in_port, data_in_port;
  logic         no_port, data_valid;
  logic [N-1:0] active_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, plus the last winner for rotation.
  int m_owner, m_addr, m_last, m_dport, m_dval;

  mtx4x2_out_arb #(.NUM_PORTS(N)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .sel_in       (sel_in),
    .trans_in     (trans_in),
    .lock_in      (lock_in),
    .HREADYM      (HREADYM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .active_out   (active_out),
    .data_in_port (data_in_port),
    .data_valid   (data_valid)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tr(input int p);
    return int'((trans_in >> (2 * p)) & 8'h3);
  endfunction

  function automatic int pick();
`ifdef MTX4X2_ARB_FIXED_PRI_EN
    for (int j = 0; j < N; j++)
      if (sel_in[j] && tr(j) >= 2) return j;
`else
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (sel_in[j] && tr(j) >= 2) return j;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_addr = 0; m_last = N - 1; m_dport = 0; m_dval = 0;
  endtask

  task automatic model_step();
    int w;
    if (!HREADYM) return;
    m_dport = m_addr;
    m_dval  = (m_owner >= 0 && tr(m_owner) >= 2) ? 1 : 0;
    if (m_owner >= 0 && lock_in[m_owner]) begin
      // locked: keep owner
    end else if (m_owner >= 0 && (tr(m_owner) == 3 || tr(m_owner) == 1)) begin
      // mid-burst: keep owner
    end else begin
      w = pick();
      if (w >= 0) begin
        m_owner = w; m_addr = w; m_last = w;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, ".addr"},  32'(addr_in_port), 32'(m_addr));
    chk_eq({tag, ".nop"},   32'(no_port),      (m_owner < 0) ? 32'd1 : 32'd0);
    chk_eq({tag, ".act"},   32'(active_out),   (m_owner < 0) ? 32'd0 : (32'd1 << m_addr));
    chk_eq({tag, ".dport"}, 32'(data_in_port), 32'(m_dport));
    chk_eq({tag, ".dval"},  32'(data_valid),   32'(m_dval));
  endtask

  task automatic step(input string tag);
    @(posedge HCLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, ".addr"},  32'(addr_in_port), 32'd0);
    chk_eq({tag, ".nop"},   32'(no_port),      32'd1);
    chk_eq({tag, ".act"},   32'(active_out),   32'd0);
    chk_eq({tag, ".dport"}, 32'(data_in_port), 32'd0);
    chk_eq({tag, ".dval"},  32'(data_valid),   32'd0);
  endtask

  initial begin
    int exp1[5];
`ifdef MTX4X2_ARB_FIXED_PRI_EN
    exp1 = '{0, 0, 0, 0, 0};
`else
    exp1 = '{0, 1, 2, 3, 0};
`endif
    HRESETn = 1'b0; HREADYM = 1'b1;
    sel_in = '0; trans_in = '0; lock_in = '0;
    model_reset();
    #12;
    chk_reset("reset");
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;

    // 1: everyone requests NONSEQ
    sel_in = 4'b1111; trans_in = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      step("s1");
      chk_eq("s1.seq", 32'(addr_in_port), 32'(exp1[i]));
      chk_eq("s1.act_const", 32'(active_out), 32'd1 << exp1[i]);
    end

    // 2: port 1 burst while port 2 waits
    sel_in = 4'b0110; trans_in = 8'h28;
    step("s2g");
    chk_eq("s2.grant1", 32'(addr_in_port), 32'd1);
    trans_in = 8'h2C;
    for (int i = 0; i < 3; i++) begin
      step("s2b");
      chk_eq("s2.hold1", 32'(addr_in_port), 32'd1);
    end
    sel_in = 4'b0100; trans_in = 8'h20;
    step("s2h");
    chk_eq("s2.grant2", 32'(addr_in_port), 32'd2);

    // 3: port 3 locked while 0 and 1 request
    sel_in = 4'b1000; trans_in = 8'h80; lock_in = 4'b1000;
    step("s3g");
    sel_in = 4'b1011; trans_in = 8'h8A;
    for (int i = 0; i < 6; i++) begin
      step("s3l");
      chk_eq("s3.lock3", 32'(addr_in_port), 32'd3);
    end
    lock_in = '0; sel_in = 4'b0011; trans_in = 8'h0A;
    step("s3r");
    chk_eq("s3.after", 32'(addr_in_port), 32'd0);

    // 4: stalled bus with changing requests
    HREADYM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel_in = 4'($urandom); trans_in = 8'($urandom);
      step("s4stall");
    end
    HREADYM = 1'b1;
    step("s4go");

    // 5: sole owner goes idle
    lock_in = '0; sel_in = 4'b0001; trans_in = 8'h02;
    step("s5a"); step("s5b");
    sel_in = '0; trans_in = '0;
    step("s5i");
    chk_eq("s5.nop", 32'(no_port), 32'd1);
    chk_eq("s5.addr", 32'(addr_in_port), 32'd0);
    step("s5d");
    chk_eq("s5.dval", 32'(data_valid), 32'd0);

    // 6: asynchronous reset mid-burst
    sel_in = 4'b0100; trans_in = 8'h20;
    step("s6g");
    trans_in = 8'h30;
    step("s6b");
    @(negedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    chk_reset("s6rst");
    model_reset();
    sel_in = '0; trans_in = '0;
    @(negedge HCLK);
    HRESETn = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      sel_in  = 4'($urandom);
      for (int p = 0; p < N; p++) begin
        trans_in[2*p +: 2] = 2'($urandom);
        lock_in[p]         = ($urandom_range(0, 5) == 0);
      end
      HREADYM = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
